// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared encodings for the bit-serial add/subtract controller.
// State and op codes live here so the controller and bit cell agree.
package serial_addsub_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// Request/response bundle between a requester and serial_addsub_ctrl.
// The master drives the operands and start; the slave returns status and result.
interface serial_addsub_ctrl_if #(parameter int WIDTH = 8);

   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;

   modport master (output start, op, a, b, input busy, done, result, cout);
   modport slave  (input start, op, a, b, output busy, done, result, cout);

endinterface

// File: rtl/fa_fs_using_demux.sv
// 1-bit full adder / full subtractor built from a 1x8 demux of {a,b,c}.
// Each output is an OR of the demux lines whose minterms make it true.
module fa_fs_using_demux
   import serial_addsub_ctrl_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic op,
   output logic s,
   output logic co
);

   logic [2:0] sel;
   logic [7:0] y;

   assign sel = {a, b, c};

   always_comb begin
      y      = '0;
      y[sel] = 1'b1;
   end

   // Sum and difference share the odd-parity minterms.
   assign s  = y[1] | y[2] | y[4] | y[7];
   assign co = (op == OP_SUB) ? (y[1] | y[2] | y[3] | y[7])
                              : (y[3] | y[5] | y[6] | y[7]);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller: one bit per clock, LSB first,
// through a single shared full adder/subtractor cell.
module serial_addsub_ctrl
   import serial_addsub_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   serial_addsub_ctrl_if.slave bus
);

   localparam int            CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, nxt;
   logic [WIDTH-1:0] a_sr, b_sr, res_r;
   logic             op_r, c_r, cout_r;
   logic [CW-1:0]    cnt;
   logic             s, co;
   logic             accept;
   logic             last_bit;

   assign accept   = bus.start && (state != RUN);
   assign last_bit = (cnt == LAST);

   fa_fs_using_demux u_cell (
      .a  (a_sr[0]),
      .b  (b_sr[0]),
      .c  (c_r),
      .op (op_r),
      .s  (s),
      .co (co)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt      = state;
      bus.busy = 1'b0;
      bus.done = 1'b0;
      case (state)
         IDLE: if (bus.start) nxt = RUN;
         RUN: begin
            bus.busy = 1'b1;
            if (last_bit) nxt = DONE;
         end
         DONE: begin
            bus.done = 1'b1;
            nxt      = bus.start ? RUN : IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // Result shifts in from the MSB end so bit 0 lands at [0] after WIDTH steps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_r  <= '0;
         op_r   <= OP_ADD;
         c_r    <= 1'b0;
         cout_r <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         a_sr <= bus.a;
         b_sr <= bus.b;
         op_r <= bus.op;
         c_r  <= 1'b0;
         cnt  <= '0;
      end else if (state == RUN) begin
         a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
         b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
         res_r <= {s, res_r[WIDTH-1:1]};
         c_r   <= co;
         cnt   <= cnt + CW'(1);
         if (last_bit) cout_r <= co;
      end
   end

   assign bus.result = res_r;
   assign bus.cout   = cout_r;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed plus randomized check of serial_addsub_ctrl against a
// plain-arithmetic (WIDTH+1)-bit reference model.
module tb_serial_addsub_ctrl;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   serial_addsub_ctrl_if #(.WIDTH(W)) bus ();

   serial_addsub_ctrl #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: (WIDTH+1)-bit arithmetic, top bit is carry or borrow.
   function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
      return op ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
   endfunction

   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
      bus.a = a; bus.b = b; bus.op = op; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   // Called right after the accepting edge; leaves the bench in the DONE cycle.
   task automatic run_check(input string tag, input logic [W:0] exp, input int glitch);
      for (int i = 0; i < W; i++) begin
         chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
         chk({tag, "_nodone"}, {31'b0, bus.done}, 32'd0);
         if (i == glitch) begin
            bus.start = 1'b1; bus.a = W'($urandom); bus.b = W'($urandom); bus.op = ~bus.op;
         end else begin
            bus.start = 1'b0;
         end
         step();
      end
      bus.start = 1'b0;
      chk({tag, "_done"}, {31'b0, bus.done}, 32'd1);
      chk({tag, "_busy_lo"}, {31'b0, bus.busy}, 32'd0);
      chk({tag, "_result"}, 32'(bus.result), 32'(exp[W-1:0]));
      chk({tag, "_cout"}, {31'b0, bus.cout}, {31'b0, exp[W]});
   endtask

   task automatic full_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic op, input int glitch);
      logic [W:0] exp;
      exp = ref_op(a, b, op);
      launch(a, b, op);
      run_check(tag, exp, glitch);
      step();
      chk({tag, "_idle_done"}, {31'b0, bus.done}, 32'd0);
      chk({tag, "_idle_busy"}, {31'b0, bus.busy}, 32'd0);
      chk({tag, "_hold"}, 32'(bus.result), 32'(exp[W-1:0]));
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic         rop;
      logic [W:0]   e;

      bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
      #3;
      chk("rst_busy", {31'b0, bus.busy}, 32'd0);
      chk("rst_done", {31'b0, bus.done}, 32'd0);
      chk("rst_result", 32'(bus.result), 32'd0);
      chk("rst_cout", {31'b0, bus.cout}, 32'd0);
      step(); step();
      rst = 1'b0;
      step();

      full_op("add_0f_01", 8'h0F, 8'h01, 1'b0, -1);
      full_op("add_ff_01", 8'hFF, 8'h01, 1'b0, -1);
      full_op("sub_05_03", 8'h05, 8'h03, 1'b1, -1);
      full_op("sub_03_05", 8'h03, 8'h05, 1'b1, -1);

      // Start pulsed in the 3rd RUN cycle must be ignored.
      full_op("ignore_start", 8'h5A, 8'h33, 1'b0, 2);

      // Idle with changing inputs keeps result/cout.
      for (int i = 0; i < 3; i++) begin
         bus.a = W'($urandom); bus.b = W'($urandom);
         step();
         chk("idle_hold_res", 32'(bus.result), 32'h8D);
         chk("idle_hold_cout", {31'b0, bus.cout}, 32'd0);
      end

      // Back-to-back: start in the DONE cycle goes straight to RUN.
      launch(8'hC8, 8'h64, 1'b0);
      run_check("b2b_first", ref_op(8'hC8, 8'h64, 1'b0), -1);
      bus.a = 8'h10; bus.b = 8'h20; bus.op = 1'b0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("b2b_no_done", {31'b0, bus.done}, 32'd0);
      run_check("b2b_second", {1'b0, 8'h30}, -1);
      step();

      // Reset between edges in the 4th RUN cycle.
      launch(8'h77, 8'h11, 1'b0);
      for (int i = 0; i < 3; i++) step();
      chk("pre_rst_busy", {31'b0, bus.busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
      chk("mid_rst_done", {31'b0, bus.done}, 32'd0);
      chk("mid_rst_result", 32'(bus.result), 32'd0);
      chk("mid_rst_cout", {31'b0, bus.cout}, 32'd0);
      step();
      #2 rst = 1'b0;
      for (int i = 0; i < W + 2; i++) begin
         step();
         chk("post_rst_nodone", {31'b0, bus.done}, 32'd0);
      end
      full_op("after_rst", 8'h01, 8'h01, 1'b0, -1);

      for (int n = 0; n < 200; n++) begin
         ra  = W'($urandom);
         rb  = W'($urandom);
         rop = 1'($urandom);
         e   = ref_op(ra, rb, rop);
         launch(ra, rb, rop);
         run_check("rand", e, -1);
         if (n % 2 == 0) step();
      end
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
